cu_sequencer: RTL
=================

Name: cu_sequencer

Overview:
- Parametrised multi-cycle control sequencer for the 32-bit RISC datapath.
- Generates per-cycle datapath control strobes from a Moore state machine keyed on IR[31:27].
- Beyond the current control unit, it adds:
  - an explicit DECODE cycle;
  - memory wait-state handshake (Mem_ready);
  - CON_ff-gated branch commit;
  - configurable register count and link register;
  - illegal-opcode flagging;
  - synchronous Stop/Resume.

Parameters:
- NUM_REGS, 16, width of one-hot R_enableIn bus (registers R0..NUM_REGS-1)
- LINK_REG, 14, register index written with PC by jal (must be < NUM_REGS)
- WAIT_LIMIT, 15, max consecutive wait cycles before bus error (used only with CU_WAIT_TIMEOUT_EN)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high; forces RESET state
- IR  in  32  instruction register; only IR[31:27] used
- Mem_ready  in  1  memory read/write complete this cycle
- CON_ff  in  1  branch condition result
- Stop  in  1  level request to halt at next instruction boundary
- Resume  in  1  leave HALT
- PCout, ZHighout, ZLowout, MDRout, HIout, LOout, Cout, Rout, BAout, InPortout  out  1 each  bus drive strobes
- MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, HIin, LOin, ZHighIn, ZLowIn, R_enable, CON_enable, OutPort_enable  out  1 each  register load strobes
- IncPC, MDR_read, RAM_write, Gra, Grb, Grc  out  1 each  misc controls
- R_enableIn  out  NUM_REGS  direct one-hot register write enable
- Run  out  1  high except in HALT
- Illegal_op  out  1  one-cycle pulse on undefined opcode
- Bus_error  out  1  sticky wait-timeout flag
- State  out  6  current state encoding (debug)

Behaviour:
- Outputs are a pure Moore decode of state; every control not listed for a state is 0.
- There are no intra-state delays.
- Reset, asynchronous:
  - state goes to RESET;
  - all controls are 0, R_enableIn = 0, Bus_error = 0, Illegal_op = 0, Run = 1.
- Reset mid-instruction abandons the instruction; no partial strobes survive the next edge.
- RESET moves to FETCH0.
- Fetch sequence:
  - FETCH0: PCout, MAR_enable.
  - FETCH1: MDR_read, MDR_enable; holds while Mem_ready = 0.
  - FETCH2: MDRout, IR_enable, PC_enable, IncPC.
  - DECODE: no controls; branches on IR[31:27].
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, br 10010, jr 10011, jal 10100, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010.
- ALU3 (add, sub, and, or, shl, shr, rol, ror):
  - T3: Grb, Rout, Y_enable.
  - T4: Grc, Rout, ZHighIn, ZLowIn.
  - T5: ZLowout, Gra, R_enable.
- IMM (addi, andi, ori, ldi):
  - T3: Grb, Y_enable, plus BAout for ldi or Rout otherwise.
  - T4: Cout, ZHighIn, ZLowIn.
  - T5: ZLowout, Gra, R_enable.
- MD (mul, div):
  - T3 and T4 as ALU3.
  - T5: ZLowout, LOin.
  - T6: ZHighout, HIin.
- UN (neg, not):
  - T3: Grb, Rout, ZHighIn, ZLowIn.
  - T4: ZLowout, Gra, R_enable.
- ld:
  - T3: Grb, BAout, Y_enable.
  - T4: Cout, ZHighIn, ZLowIn.
  - T5: ZLowout, MAR_enable.
  - T6: MDR_read, MDR_enable; waits on Mem_ready.
  - T7: MDRout, Gra, R_enable.
- st:
  - T3 to T5 as ld.
  - T6: Gra, Rout, MDR_enable.
  - T7: MDRout, RAM_write; waits on Mem_ready.
- br:
  - T3: Gra, Rout, CON_enable.
  - T4: PCout, Y_enable.
  - T5: Cout, ZHighIn, ZLowIn.
  - T6: ZLowout, plus PC_enable = CON_ff sampled combinationally in T6.
- jr: T3 asserts Gra, Rout, PC_enable.
- jal:
  - T3: PCout, R_enableIn = 1 << LINK_REG.
  - T4: Gra, Rout, PC_enable.
- mfhi / mflo: T3 asserts Gra, R_enable, plus HIout or LOout.
- in: T3 asserts Gra, R_enable, InPortout.
- out: T3 asserts Gra, Rout, OutPort_enable.
- nop: DECODE goes straight to the boundary.
- Illegal opcodes 11011..11111:
  - Illegal_op = 1 for the DECODE cycle;
  - executed as nop.
- Instruction boundary: after the last T-state (or nop/illegal DECODE), next state is HALT if Stop = 1, else FETCH0.
- halt opcode: DECODE goes to HALT.
- HALT:
  - Run = 0, no controls asserted;
  - exits to FETCH0 when Resume = 1 and Stop = 0;
  - Resume is ignored in all other states.
- Wait states:
  - a waiting state re-asserts its controls every cycle;
  - it advances on the edge where Mem_ready = 1;
  - Mem_ready in non-wait states is ignored.

Optional Feature:
- Macro: CU_WAIT_TIMEOUT_EN.
- Defined:
  - a counter clears on entry to any wait state and increments each wait cycle with Mem_ready = 0;
  - when it reaches WAIT_LIMIT, next state is HALT and Bus_error sets;
  - Bus_error stays set until Reset;
  - Resume is ignored while Bus_error = 1.
- Undefined: waits are unbounded, Bus_error is tied 0, and no counter exists.

Decomposition:
- Package cu_pkg holds:
  - the opcode localparams;
  - the state enum typedef (6-bit), exported on State;
  - the instruction class enum.
- One sub-module, cu_wait_timer, holds the counter and limit compare; it is instantiated only under CU_WAIT_TIMEOUT_EN.

Test Plan:
- Reset release, IR = 0x18918000 (add), Mem_ready = 1:
  - states RESET, FETCH0, FETCH1, FETCH2, DECODE, T3, T4, T5, FETCH0;
  - R_enable = 1 only in T5;
  - instruction totals 7 cycles.
- ld with Mem_ready held low 3 cycles in T6:
  - T6 asserted 4 cycles, then T7 MDRout, Gra, R_enable;
  - RAM_write never asserted.
- br twice, CON_ff = 0 then 1: PC_enable in T6 is 0 then 1; all other T6 controls are identical.
- jal with NUM_REGS = 32, LINK_REG = 31: in T3, R_enableIn = 0x80000000 and PCout = 1.
- IR[31:27] = 11101: Illegal_op pulses once in DECODE, then FETCH0; Stop = 1 during st T5 reaches HALT after T7 with Run = 0; Resume = 1 returns to FETCH0.
- With CU_WAIT_TIMEOUT_EN and WAIT_LIMIT = 4, Mem_ready stuck 0 in FETCH1:
  - HALT after 4 wait cycles, Bus_error = 1;
  - Resume is ignored;
  - Reset clears Bus_error.

Source files
------------

// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, state and instruction-class enums, control bundle for cu_sequencer
package cu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [5:0] {
    S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE, S_HALT,
    S_ALU_T3, S_ALU_T4, S_ALU_T5,
    S_IMM_T3, S_LDI_T3, S_IMM_T4, S_IMM_T5,
    S_MD_T3, S_MD_T4, S_MD_T5, S_MD_T6,
    S_UN_T3, S_UN_T4,
    S_LD_T3, S_LD_T4, S_LD_T5, S_LD_T6, S_LD_T7,
    S_ST_T3, S_ST_T4, S_ST_T5, S_ST_T6, S_ST_T7,
    S_BR_T3, S_BR_T4, S_BR_T5, S_BR_T6,
    S_JR_T3, S_JAL_T3, S_JAL_T4,
    S_MFHI_T3, S_MFLO_T3, S_IN_T3, S_OUT_T3
  } state_t;

  typedef enum logic [4:0] {
    C_ALU, C_IMM, C_MD, C_UN, C_LD, C_ST, C_BR, C_JR, C_JAL,
    C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
  } cls_t;

  // Field order matches the output port order so the top can unpack it in one assign
  typedef struct packed {
    logic pc_out, zhi_out, zlo_out, mdr_out, hi_out, lo_out, c_out, r_out, ba_out, inport_out;
    logic mar_en, pc_en, mdr_en, ir_en, y_en, hi_in, lo_in, zhi_in, zlo_in, r_en, con_en, outport_en;
    logic inc_pc, mdr_read, ram_write, gra, grb, grc;
  } ctl_t;

  function automatic cls_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_ROL, OP_ROR: op_class = C_ALU;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:                              op_class = C_IMM;
      OP_MUL, OP_DIV:                                                op_class = C_MD;
      OP_NEG, OP_NOT:                                                op_class = C_UN;
      OP_LD:   op_class = C_LD;
      OP_ST:   op_class = C_ST;
      OP_BR:   op_class = C_BR;
      OP_JR:   op_class = C_JR;
      OP_JAL:  op_class = C_JAL;
      OP_IN:   op_class = C_IN;
      OP_OUT:  op_class = C_OUT;
      OP_MFHI: op_class = C_MFHI;
      OP_MFLO: op_class = C_MFLO;
      OP_NOP:  op_class = C_NOP;
      OP_HALT: op_class = C_HALT;
      default: op_class = C_ILL;
    endcase
  endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// cu_wait_timer: counts consecutive memory wait cycles and raises a sticky bus error at WAIT_LIMIT
module cu_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic in_wait,
  input  logic Mem_ready,
  output logic timeout,
  output logic Bus_error
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  logic [CW-1:0] cnt;

  assign timeout = in_wait && !Mem_ready && (cnt == CW'(WAIT_LIMIT - 1));

  // Wait states are never adjacent, so clearing outside a stall equals clearing on entry
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt       <= '0;
      Bus_error <= 1'b0;
    end else begin
      cnt <= (in_wait && !Mem_ready) ? cnt + 1'b1 : '0;
      if (timeout) Bus_error <= 1'b1;
    end
  end

endmodule

// File: rtl/cu_sequencer.sv
// cu_sequencer: multi-cycle Moore control sequencer; CU_WAIT_TIMEOUT_EN adds a memory wait timeout
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int LINK_REG   = 14,
  parameter int WAIT_LIMIT = 15
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [31:0]         IR,
  input  logic                Mem_ready,
  input  logic                CON_ff,
  input  logic                Stop,
  input  logic                Resume,
  output logic                PCout,
  output logic                ZHighout,
  output logic                ZLowout,
  output logic                MDRout,
  output logic                HIout,
  output logic                LOout,
  output logic                Cout,
  output logic                Rout,
  output logic                BAout,
  output logic                InPortout,
  output logic                MAR_enable,
  output logic                PC_enable,
  output logic                MDR_enable,
  output logic                IR_enable,
  output logic                Y_enable,
  output logic                HIin,
  output logic                LOin,
  output logic                ZHighIn,
  output logic                ZLowIn,
  output logic                R_enable,
  output logic                CON_enable,
  output logic                OutPort_enable,
  output logic                IncPC,
  output logic                MDR_read,
  output logic                RAM_write,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic [NUM_REGS-1:0] R_enableIn,
  output logic                Run,
  output logic                Illegal_op,
  output logic                Bus_error,
  output logic [5:0]          State
);

  if (LINK_REG >= NUM_REGS || WAIT_LIMIT < 1) begin : g_bad_cfg
    $error("cu_sequencer: LINK_REG must be below NUM_REGS and WAIT_LIMIT at least 1");
  end

  state_t     state, nxt;
  ctl_t       c;
  logic [4:0] op;
  logic       in_wait, timeout, bus_err, unused_ir;
  state_t     bnd;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign in_wait   = state inside {S_FETCH1, S_LD_T6, S_ST_T7};
  assign bnd       = Stop ? S_HALT : S_FETCH0;

`ifdef CU_WAIT_TIMEOUT_EN
  cu_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .in_wait  (in_wait),
    .Mem_ready(Mem_ready),
    .timeout  (timeout),
    .Bus_error(bus_err)
  );
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_RESET;
    else       state <= nxt;
  end

  // Next-state: fetch, decode dispatch, per-class T-steps, boundary, halt and waits
  always_comb begin
    nxt = state;
    case (state)
      S_RESET:  nxt = S_FETCH0;
      S_FETCH0: nxt = S_FETCH1;
      S_FETCH1: nxt = Mem_ready ? S_FETCH2 : S_FETCH1;
      S_FETCH2: nxt = S_DECODE;
      S_DECODE:
        case (op_class(op))
          C_ALU:   nxt = S_ALU_T3;
          C_IMM:   nxt = (op == OP_LDI) ? S_LDI_T3 : S_IMM_T3;
          C_MD:    nxt = S_MD_T3;
          C_UN:    nxt = S_UN_T3;
          C_LD:    nxt = S_LD_T3;
          C_ST:    nxt = S_ST_T3;
          C_BR:    nxt = S_BR_T3;
          C_JR:    nxt = S_JR_T3;
          C_JAL:   nxt = S_JAL_T3;
          C_IN:    nxt = S_IN_T3;
          C_OUT:   nxt = S_OUT_T3;
          C_MFHI:  nxt = S_MFHI_T3;
          C_MFLO:  nxt = S_MFLO_T3;
          C_HALT:  nxt = S_HALT;
          default: nxt = bnd;
        endcase
      S_HALT:   nxt = (Resume && !Stop && !bus_err) ? S_FETCH0 : S_HALT;
      S_ALU_T3: nxt = S_ALU_T4;
      S_ALU_T4: nxt = S_ALU_T5;
      S_IMM_T3, S_LDI_T3: nxt = S_IMM_T4;
      S_IMM_T4: nxt = S_IMM_T5;
      S_MD_T3:  nxt = S_MD_T4;
      S_MD_T4:  nxt = S_MD_T5;
      S_MD_T5:  nxt = S_MD_T6;
      S_UN_T3:  nxt = S_UN_T4;
      S_LD_T3:  nxt = S_LD_T4;
      S_LD_T4:  nxt = S_LD_T5;
      S_LD_T5:  nxt = S_LD_T6;
      S_LD_T6:  nxt = Mem_ready ? S_LD_T7 : S_LD_T6;
      S_ST_T3:  nxt = S_ST_T4;
      S_ST_T4:  nxt = S_ST_T5;
      S_ST_T5:  nxt = S_ST_T6;
      S_ST_T6:  nxt = S_ST_T7;
      S_ST_T7:  nxt = Mem_ready ? bnd : S_ST_T7;
      S_BR_T3:  nxt = S_BR_T4;
      S_BR_T4:  nxt = S_BR_T5;
      S_BR_T5:  nxt = S_BR_T6;
      S_JAL_T3: nxt = S_JAL_T4;
      S_ALU_T5, S_IMM_T5, S_MD_T6, S_UN_T4, S_LD_T7, S_BR_T6, S_JR_T3, S_JAL_T4,
      S_MFHI_T3, S_MFLO_T3, S_IN_T3, S_OUT_T3: nxt = bnd;
      default:  nxt = S_RESET;
    endcase
    if (timeout) nxt = S_HALT;
  end

  // Control strobes decoded from state alone, except the CON_ff-gated branch commit
  always_comb begin
    c = '0;
    case (state)
      S_FETCH0:                     begin c.pc_out = 1'b1; c.mar_en = 1'b1; end
      S_FETCH1, S_LD_T6:            begin c.mdr_read = 1'b1; c.mdr_en = 1'b1; end
      S_FETCH2:                     begin c.mdr_out = 1'b1; c.ir_en = 1'b1; c.pc_en = 1'b1; c.inc_pc = 1'b1; end
      S_ALU_T3, S_MD_T3, S_IMM_T3:  begin c.grb = 1'b1; c.r_out = 1'b1; c.y_en = 1'b1; end
      S_LDI_T3, S_LD_T3, S_ST_T3:   begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_en = 1'b1; end
      S_ALU_T4, S_MD_T4:            begin c.grc = 1'b1; c.r_out = 1'b1; c.zhi_in = 1'b1; c.zlo_in = 1'b1; end
      S_IMM_T4, S_LD_T4, S_ST_T4, S_BR_T5: begin c.c_out = 1'b1; c.zhi_in = 1'b1; c.zlo_in = 1'b1; end
      S_ALU_T5, S_IMM_T5, S_UN_T4:  begin c.zlo_out = 1'b1; c.gra = 1'b1; c.r_en = 1'b1; end
      S_MD_T5:                      begin c.zlo_out = 1'b1; c.lo_in = 1'b1; end
      S_MD_T6:                      begin c.zhi_out = 1'b1; c.hi_in = 1'b1; end
      S_UN_T3:                      begin c.grb = 1'b1; c.r_out = 1'b1; c.zhi_in = 1'b1; c.zlo_in = 1'b1; end
      S_LD_T5, S_ST_T5:             begin c.zlo_out = 1'b1; c.mar_en = 1'b1; end
      S_LD_T7:                      begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_en = 1'b1; end
      S_ST_T6:                      begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_en = 1'b1; end
      S_ST_T7:                      begin c.mdr_out = 1'b1; c.ram_write = 1'b1; end
      S_BR_T3:                      begin c.gra = 1'b1; c.r_out = 1'b1; c.con_en = 1'b1; end
      S_BR_T4:                      begin c.pc_out = 1'b1; c.y_en = 1'b1; end
      S_BR_T6:                      begin c.zlo_out = 1'b1; c.pc_en = CON_ff; end
      S_JR_T3, S_JAL_T4:            begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_en = 1'b1; end
      S_JAL_T3:                     c.pc_out = 1'b1;
      S_MFHI_T3:                    begin c.gra = 1'b1; c.r_en = 1'b1; c.hi_out = 1'b1; end
      S_MFLO_T3:                    begin c.gra = 1'b1; c.r_en = 1'b1; c.lo_out = 1'b1; end
      S_IN_T3:                      begin c.gra = 1'b1; c.r_en = 1'b1; c.inport_out = 1'b1; end
      S_OUT_T3:                     begin c.gra = 1'b1; c.r_out = 1'b1; c.outport_en = 1'b1; end
      default:                      c = '0;
    endcase
  end

  assign {PCout, ZHighout, ZLowout, MDRout, HIout, LOout, Cout, Rout, BAout, InPortout,
          MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, HIin, LOin, ZHighIn, ZLowIn,
          R_enable, CON_enable, OutPort_enable, IncPC, MDR_read, RAM_write, Gra, Grb, Grc} = c;

  assign R_enableIn = (state == S_JAL_T3) ? NUM_REGS'(1) << LINK_REG : '0;
  assign Run        = state != S_HALT;
  assign Illegal_op = (state == S_DECODE) && (op_class(op) == C_ILL);
  assign Bus_error  = bus_err;
  assign State      = state;

endmodule
